// File: rtl/unpool_layer.sv
// 2x nearest-neighbour upsampler: each input pixel is emitted twice, and each
// row is replayed from a line buffer to form the following output row.
module unpool_layer #(
  parameter int DATA_W = 32,
  parameter int IN_W   = 12,
  parameter int IN_H   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cal_start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_data_vld,
  output logic              in_ready,
  output logic [DATA_W-1:0] up_data,
  output logic              up_data_vld,
  input  logic              up_ready,
  output logic              up_eol,
  output logic              frame_done
);
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;

  typedef enum logic [1:0] {LOAD, DUP0, DUP1, REPLAY} state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              half;
  logic [DATA_W-1:0] line_buf [IN_W];

  logic          out_xfer, last_col, last_row;
  logic [CW-1:0] col_inc;

  assign in_ready = (state == LOAD);
  assign out_xfer = up_data_vld & up_ready;
  assign last_col = (col == CW'(IN_W - 1));
  assign last_row = (row == RW'(IN_H - 1));
  assign col_inc  = col + CW'(1);

  // Line buffer is never cleared; every entry is rewritten before it is replayed.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_data_vld && !cal_start)
      line_buf[col] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      col         <= '0;
      row         <= '0;
      half        <= 1'b0;
      up_data     <= '0;
      up_data_vld <= 1'b0;
      up_eol      <= 1'b0;
      frame_done  <= 1'b0;
    end else if (cal_start) begin
      state       <= LOAD;
      col         <= '0;
      row         <= '0;
      half        <= 1'b0;
      up_data     <= '0;
      up_data_vld <= 1'b0;
      up_eol      <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LOAD: if (in_data_vld) begin
          up_data     <= in_data;
          up_data_vld <= 1'b1;
          up_eol      <= 1'b0;
          state       <= DUP0;
        end
        DUP0: if (out_xfer) begin
          up_eol <= last_col;
          state  <= DUP1;
        end
        DUP1: if (out_xfer) begin
          if (!last_col) begin
            col         <= col_inc;
            up_data_vld <= 1'b0;
            state       <= LOAD;
          end else begin
            col     <= '0;
            half    <= 1'b0;
            up_data <= line_buf[0];
            up_eol  <= 1'b0;
            state   <= REPLAY;
          end
        end
        REPLAY: if (out_xfer) begin
          if (!half) begin
            half   <= 1'b1;
            up_eol <= last_col;
          end else if (!last_col) begin
            half    <= 1'b0;
            col     <= col_inc;
            up_data <= line_buf[col_inc];
            up_eol  <= 1'b0;
          end else begin
            up_data_vld <= 1'b0;
            col         <= '0;
            half        <= 1'b0;
            state       <= LOAD;
            if (last_row) begin
              row        <= '0;
              frame_done <= 1'b1;
            end else begin
              row <= row + RW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
